pattern_sweeper: RTL and testbench



---
 rtl/pattern_sweeper_pkg.sv | 17 +
 rtl/pattern_sweeper_misr.sv | 32 +++
 rtl/pattern_sweeper.sv | 109 ++++++++++
 tb/tb_pattern_sweeper.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pattern_sweeper_pkg.sv
// Shared types and helpers for the pattern sweeper: FSM state encoding,
// dwell counter width and the binary-to-Gray encoder.
package pattern_sweeper_pkg;

  localparam int DCNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [15:0] gray_enc(input logic [15:0] i);
    return i ^ (i >> 1);
  endfunction

endpackage

// File: rtl/pattern_sweeper_misr.sv
// Rotate-left-and-XOR signature accumulator; folds one response word per
// enabled cycle, cleared at the start of every sweep.
module pattern_sweeper_misr #(
  parameter int RESP_W = 1,
  parameter int SIG_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [RESP_W-1:0] din,
  output logic [SIG_W-1:0]  sig
);

  logic [SIG_W-1:0] din_ext;

  always_comb begin
    din_ext = '0;
    din_ext[RESP_W-1:0] = din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], sig[SIG_W-1]} ^ din_ext;
    end
  end

endmodule

// File: rtl/pattern_sweeper.sv
// Exhaustive stimulus sequencer: walks all 2^WIDTH input patterns in binary
// or Gray order, holds each for DWELL cycles and signs the sampled responses.
module pattern_sweeper
  import pattern_sweeper_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int DWELL  = 10,
  parameter int RESP_W = 1,
  parameter int SIG_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              gray,
  input  logic [RESP_W-1:0] resp_in,
  output logic [WIDTH-1:0]  pattern,
  output logic              sample,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature
);

  localparam logic [DCNT_W-1:0] DWELL_LAST = DCNT_W'(DWELL - 1);
  localparam logic [WIDTH-1:0]  IDX_LAST   = '1;

  state_t              state, state_next;
  logic [WIDTH-1:0]    idx, idx_next, idx_inc;
  logic [DCNT_W-1:0]   dcnt, dcnt_next;
  logic                gray_q, gray_next;
  logic [WIDTH-1:0]    pattern_next;
  logic                last_cycle;
  logic                misr_clr, misr_en;

  assign idx_inc    = idx + WIDTH'(1);
  assign last_cycle = (dcnt == DWELL_LAST);
  assign sample     = (state == DRIVE) && last_cycle;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      dcnt    <= '0;
      gray_q  <= 1'b0;
      pattern <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      idx     <= idx_next;
      dcnt    <= dcnt_next;
      gray_q  <= gray_next;
      pattern <= pattern_next;
      busy    <= (state_next == DRIVE);
      done    <= (state_next == DONE);
    end
  end

  // The terminal check happens before the increment, so idx never wraps.
  always_comb begin
    state_next   = state;
    idx_next     = idx;
    dcnt_next    = dcnt;
    gray_next    = gray_q;
    pattern_next = pattern;
    misr_clr     = 1'b0;
    misr_en      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next   = DRIVE;
          idx_next     = '0;
          dcnt_next    = '0;
          gray_next    = gray;
          pattern_next = '0;
          misr_clr     = 1'b1;
        end
      end
      DRIVE: begin
        if (last_cycle) begin
          misr_en = 1'b1;
          if (idx == IDX_LAST) begin
            state_next   = DONE;
            pattern_next = '0;
          end else begin
            idx_next     = idx_inc;
            dcnt_next    = '0;
            pattern_next = gray_q ? WIDTH'(gray_enc(16'(idx_inc))) : idx_inc;
          end
        end else begin
          dcnt_next = dcnt + DCNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  pattern_sweeper_misr #(
    .RESP_W (RESP_W),
    .SIG_W  (SIG_W)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (misr_clr),
    .en    (misr_en),
    .din   (resp_in),
    .sig   (signature)
  );

endmodule

// File: tb/tb_pattern_sweeper.sv
// Directed self-checking bench for pattern_sweeper: a scoreboard queue of
// expected per-cycle pattern/sample values is filled when a sweep starts.
module tb_pattern_sweeper;

  logic clk = 1'b0;
  logic rst_n;

  logic        start_a, gray_a;
  logic [1:0]  resp_a, pattern_a;
  logic        sample_a, busy_a, done_a;
  logic [15:0] sig_a;

  logic        start_b, gray_b;
  logic        resp_b;
  logic [2:0]  pattern_b;
  logic        sample_b, busy_b, done_b;
  logic [15:0] sig_b;

  typedef struct {
    logic [1:0] pat;
    logic       smp;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_sig;
  int          tests    = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  assign resp_a = pattern_a;
  assign resp_b = 1'b1;
  assign gray_b = 1'b0;

  pattern_sweeper #(.WIDTH(2), .DWELL(10), .RESP_W(2), .SIG_W(16)) dut_a (
    .clk (clk), .rst_n (rst_n), .start (start_a), .gray (gray_a),
    .resp_in (resp_a), .pattern (pattern_a), .sample (sample_a),
    .busy (busy_a), .done (done_a), .signature (sig_a)
  );

  pattern_sweeper #(.WIDTH(3), .DWELL(1), .RESP_W(1), .SIG_W(16)) dut_b (
    .clk (clk), .rst_n (rst_n), .start (start_b), .gray (gray_b),
    .resp_in (resp_b), .pattern (pattern_b), .sample (sample_b),
    .busy (busy_b), .done (done_b), .signature (sig_b)
  );

  function automatic logic [15:0] rot(input logic [15:0] s);
    return {s[14:0], s[15]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Starts a sweep on dut_a and loads the scoreboard with its expected trace.
  task automatic apply_stimulus(input logic g);
    logic [1:0] enc;
    exp_q.delete();
    exp_sig = '0;
    for (int p = 0; p < 4; p++) begin
      enc = g ? 2'(p ^ (p >> 1)) : 2'(p);
      for (int d = 0; d < 10; d++) exp_q.push_back('{pat: enc, smp: (d == 9)});
      exp_sig = rot(exp_sig) ^ {14'd0, enc};
    end
    start_a = 1'b1;
    gray_a  = g;
    tick();
    start_a = 1'b0;
    check_output("start_done_clr", done_a, 0);
    check_output("start_sig_clr", sig_a, 0);
  endtask

  task automatic check_sweep(input int poke_at, input int reset_at);
    exp_t e;
    int   cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cyc++;
      check_output($sformatf("pattern_c%0d", cyc), pattern_a, e.pat);
      check_output($sformatf("sample_c%0d", cyc), sample_a, e.smp);
      check_output($sformatf("busy_c%0d", cyc), busy_a, 1);
      check_output($sformatf("done_low_c%0d", cyc), done_a, 0);
      if (cyc == poke_at) begin
        start_a = 1'b1;
        gray_a  = ~gray_a;
      end
      if (cyc == poke_at + 1) start_a = 1'b0;
      if (cyc == reset_at) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_output("rst_pattern", pattern_a, 0);
        check_output("rst_sample", sample_a, 0);
        check_output("rst_busy", busy_a, 0);
        check_output("rst_done", done_a, 0);
        check_output("rst_sig", sig_a, 0);
        tick();
        check_output("rst_idle_busy", busy_a, 0);
        check_output("rst_idle_done", done_a, 0);
        exp_q.delete();
        return;
      end
      tick();
    end
    check_output("end_done", done_a, 1);
    check_output("end_busy", busy_a, 0);
    check_output("end_sample", sample_a, 0);
    check_output("end_pattern", pattern_a, 0);
    check_output("end_sig", sig_a, 32'(exp_sig));
  endtask

  initial begin
    logic [15:0] sig_b_exp;
    rst_n   = 1'b0;
    start_a = 1'b0;
    gray_a  = 1'b0;
    start_b = 1'b0;
    tick();
    tick();
    check_output("reset_pattern", pattern_a, 0);
    check_output("reset_sample", sample_a, 0);
    check_output("reset_busy", busy_a, 0);
    check_output("reset_done", done_a, 0);
    check_output("reset_sig", sig_a, 0);
    rst_n = 1'b1;
    tick();
    check_output("idle_busy", busy_a, 0);

    $display("[TB] binary sweep");
    apply_stimulus(1'b0);
    check_sweep(-1, -1);

    $display("[TB] gray sweep restarted from DONE");
    apply_stimulus(1'b1);
    check_sweep(-1, -1);

    $display("[TB] start and gray toggle ignored mid-sweep");
    apply_stimulus(1'b0);
    check_sweep(5, -1);

    $display("[TB] reset mid-sweep then full sweep");
    apply_stimulus(1'b0);
    check_sweep(-1, 15);
    apply_stimulus(1'b0);
    check_sweep(-1, -1);

    $display("[TB] width 3 dwell 1 sweep");
    sig_b_exp = '0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_output($sformatf("b_pattern_%0d", i), pattern_b, i);
      check_output($sformatf("b_sample_%0d", i), sample_b, 1);
      check_output($sformatf("b_busy_%0d", i), busy_b, 1);
      sig_b_exp = rot(sig_b_exp) ^ 16'd1;
      tick();
    end
    check_output("b_done", done_b, 1);
    check_output("b_busy_end", busy_b, 0);
    check_output("b_sample_end", sample_b, 0);
    check_output("b_sig", sig_b, 32'(sig_b_exp));

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
